// File: rtl/tvip_axi_types_pkg.sv
// Shared AXI burst types and address helpers used by the burst beat generator.
// Address helpers work on a fixed 64-bit address; callers zero-extend narrower buses.
package tvip_axi_types_pkg;

  localparam int TVIP_AXI_MAX_ADDRESS_WIDTH = 64;

  typedef logic [TVIP_AXI_MAX_ADDRESS_WIDTH-1:0] tvip_axi_address;

  typedef enum logic [2:0] {
    TVIP_AXI_BURST_SIZE_1_BYTE    = 3'd0,
    TVIP_AXI_BURST_SIZE_2_BYTES   = 3'd1,
    TVIP_AXI_BURST_SIZE_4_BYTES   = 3'd2,
    TVIP_AXI_BURST_SIZE_8_BYTES   = 3'd3,
    TVIP_AXI_BURST_SIZE_16_BYTES  = 3'd4,
    TVIP_AXI_BURST_SIZE_32_BYTES  = 3'd5,
    TVIP_AXI_BURST_SIZE_64_BYTES  = 3'd6,
    TVIP_AXI_BURST_SIZE_128_BYTES = 3'd7
  } tvip_axi_burst_size;

  typedef enum logic [1:0] {
    TVIP_AXI_FIXED_BURST    = 2'b00,
    TVIP_AXI_INCREMENTING_BURST = 2'b01,
    TVIP_AXI_WRAPPING_BURST = 2'b10,
    TVIP_AXI_RESERVED_BURST = 2'b11
  } tvip_axi_burst_type;

  typedef enum logic [0:0] {
    BEAT_GEN_IDLE  = 1'b0,
    BEAT_GEN_BURST = 1'b1
  } tvip_axi_beat_gen_state_e;

  function automatic tvip_axi_address calc_size_bytes(tvip_axi_burst_size size);
    return tvip_axi_address'(1) << size;
  endfunction

  function automatic tvip_axi_address calc_burst_bytes(tvip_axi_burst_size size,
                                                       logic [7:0] length);
    return (tvip_axi_address'(length) + tvip_axi_address'(1)) << size;
  endfunction

  function automatic tvip_axi_address calc_aligned_address(tvip_axi_address address,
                                                           tvip_axi_burst_size size);
    return address & ~(calc_size_bytes(size) - tvip_axi_address'(1));
  endfunction

  // Only meaningful for legal WRAP lengths, where the burst span is a power of two.
  function automatic tvip_axi_address calc_wrap_boundary(tvip_axi_address address,
                                                         tvip_axi_burst_size size,
                                                         logic [7:0] length);
    return address & ~(calc_burst_bytes(size, length) - tvip_axi_address'(1));
  endfunction

  function automatic logic crosses_4kb_boundary(tvip_axi_address address,
                                                tvip_axi_burst_size size,
                                                logic [7:0] length);
    tvip_axi_address last_byte;
    last_byte = calc_aligned_address(address, size) + calc_burst_bytes(size, length)
              - tvip_axi_address'(1);
    return address[TVIP_AXI_MAX_ADDRESS_WIDTH-1:12] != last_byte[TVIP_AXI_MAX_ADDRESS_WIDTH-1:12];
  endfunction

endpackage

// File: rtl/tvip_axi_burst_beat_generator_if.sv
// Request and beat channels of the burst beat generator.
interface tvip_axi_burst_beat_generator_if #(
  parameter int ADDRESS_WIDTH = 64,
  parameter int DATA_WIDTH    = 32,
  parameter int ID_WIDTH      = 8
);

  // Both channels: a transfer happens on a rising clock edge where valid && ready;
  // the sender holds its payload stable and valid high until that edge.
  logic                     req_valid;
  logic                     req_ready;
  logic [ID_WIDTH-1:0]      req_id;
  logic [ADDRESS_WIDTH-1:0] req_address;
  logic [7:0]               req_length;
  logic [2:0]               req_size;
  logic [1:0]               req_burst;
  logic                     req_error;

  logic                     beat_valid;
  logic                     beat_ready;
  logic [ID_WIDTH-1:0]      beat_id;
  logic [ADDRESS_WIDTH-1:0] beat_address;
  logic [DATA_WIDTH/8-1:0]  beat_strobe;
  logic [7:0]               beat_index;
  logic                     beat_last;

  modport master (
    output req_valid, req_id, req_address, req_length, req_size, req_burst, beat_ready,
    input  req_ready, req_error, beat_valid, beat_id, beat_address, beat_strobe,
           beat_index, beat_last
  );

  modport slave (
    input  req_valid, req_id, req_address, req_length, req_size, req_burst, beat_ready,
    output req_ready, req_error, beat_valid, beat_id, beat_address, beat_strobe,
           beat_index, beat_last
  );

endinterface

// File: rtl/tvip_axi_strobe_calc.sv
// Byte-lane strobe of one beat from the low address byte and the transfer size.
module tvip_axi_strobe_calc
  import tvip_axi_types_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [7:0]              address_lsb,
  input  tvip_axi_burst_size      size,
  output logic [DATA_WIDTH/8-1:0] strobe
);

  localparam int BYTE_LANES = DATA_WIDTH / 8;

  logic [7:0] first_lane;
  logic [7:0] size_bytes;
  logic [7:0] last_lane;

  // Lanes below an unaligned start are dropped; the top lane is the end of the aligned slot.
  always_comb begin
    first_lane = address_lsb & 8'(BYTE_LANES - 1);
    size_bytes = 8'(1) << size;
    last_lane  = (first_lane & ~(size_bytes - 8'd1)) + size_bytes - 8'd1;
    strobe     = '0;
    for (int i = 0; i < BYTE_LANES; i++) begin
      strobe[i] = (8'(i) >= first_lane) && (8'(i) <= last_lane);
    end
  end

endmodule

// File: rtl/tvip_axi_burst_beat_generator.sv
// Expands one AXI address-channel request into per-beat address, strobe, index and last.
// ADDRESS_WIDTH may be at most 64; DATA_WIDTH is a power of two from 8 to 1024.
module tvip_axi_burst_beat_generator
  import tvip_axi_types_pkg::*;
#(
  parameter int ADDRESS_WIDTH = 64,
  parameter int DATA_WIDTH    = 32,
  parameter int ID_WIDTH      = 8
) (
  input  logic                            aclk,
  input  logic                            areset,
  tvip_axi_burst_beat_generator_if.slave  bus,
  output tvip_axi_beat_gen_state_e        state
);

  localparam int         BYTE_LANES = DATA_WIDTH / 8;
  localparam logic [2:0] MAX_SIZE   = 3'($clog2(BYTE_LANES));

  tvip_axi_beat_gen_state_e state_q;
  logic                     req_ready_q;
  logic                     req_error_q;
  logic                     beat_valid_q;
  logic                     beat_last_q;
  logic [ID_WIDTH-1:0]      id_q;
  logic [ADDRESS_WIDTH-1:0] beat_address_q;
  logic [7:0]               beat_index_q;
  logic [7:0]               length_q;
  tvip_axi_burst_size       size_q;
  tvip_axi_burst_type       burst_q;
  tvip_axi_address          wrap_start_q;
  tvip_axi_address          wrap_end_q;

  tvip_axi_burst_size       req_size;
  tvip_axi_burst_type       req_burst;
  tvip_axi_address          req_address;
  tvip_axi_address          req_wrap_start;
  tvip_axi_address          req_wrap_end;
  logic                     req_wrap_length_ok;
  logic                     req_illegal;

  tvip_axi_address          cur_address;
  tvip_axi_address          next_address;
  logic [BYTE_LANES-1:0]    lane_strobe;

  always_comb begin
    req_size           = tvip_axi_burst_size'(bus.req_size);
    req_burst          = tvip_axi_burst_type'(bus.req_burst);
    req_address        = tvip_axi_address'(bus.req_address);
    req_wrap_start     = calc_wrap_boundary(req_address, req_size, bus.req_length);
    req_wrap_end       = req_wrap_start + calc_burst_bytes(req_size, bus.req_length);
    req_wrap_length_ok = (bus.req_length == 8'd1) || (bus.req_length == 8'd3) ||
                         (bus.req_length == 8'd7) || (bus.req_length == 8'd15);
    req_illegal        = bus.req_size > MAX_SIZE;
    case (req_burst)
      TVIP_AXI_FIXED_BURST: begin
      end
      TVIP_AXI_INCREMENTING_BURST: begin
        if (crosses_4kb_boundary(req_address, req_size, bus.req_length)) begin
          req_illegal = 1'b1;
        end
      end
      TVIP_AXI_WRAPPING_BURST: begin
        if (!req_wrap_length_ok ||
            (req_address != calc_aligned_address(req_address, req_size))) begin
          req_illegal = 1'b1;
        end
      end
      default: req_illegal = 1'b1;
    endcase
  end

  // INCR realigns after an unaligned first beat; WRAP folds back at the end of its window.
  always_comb begin
    cur_address  = tvip_axi_address'(beat_address_q);
    next_address = cur_address;
    case (burst_q)
      TVIP_AXI_INCREMENTING_BURST: begin
        next_address = calc_aligned_address(cur_address, size_q) + calc_size_bytes(size_q);
      end
      TVIP_AXI_WRAPPING_BURST: begin
        next_address = cur_address + calc_size_bytes(size_q);
        if (next_address == wrap_end_q) begin
          next_address = wrap_start_q;
        end
      end
      default: next_address = cur_address;
    endcase
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state_q        <= BEAT_GEN_IDLE;
      req_ready_q    <= 1'b1;
      req_error_q    <= 1'b0;
      beat_valid_q   <= 1'b0;
      beat_last_q    <= 1'b0;
      id_q           <= '0;
      beat_address_q <= '0;
      beat_index_q   <= '0;
      length_q       <= '0;
      size_q         <= TVIP_AXI_BURST_SIZE_1_BYTE;
      burst_q        <= TVIP_AXI_FIXED_BURST;
      wrap_start_q   <= '0;
      wrap_end_q     <= '0;
    end else begin
      req_error_q <= 1'b0;
      case (state_q)
        BEAT_GEN_IDLE: begin
          if (bus.req_valid && req_ready_q) begin
            if (req_illegal) begin
              req_error_q <= 1'b1;
            end else begin
              state_q        <= BEAT_GEN_BURST;
              req_ready_q    <= 1'b0;
              beat_valid_q   <= 1'b1;
              beat_last_q    <= bus.req_length == 8'd0;
              id_q           <= bus.req_id;
              beat_address_q <= bus.req_address;
              beat_index_q   <= '0;
              length_q       <= bus.req_length;
              size_q         <= req_size;
              burst_q        <= req_burst;
              wrap_start_q   <= req_wrap_start;
              wrap_end_q     <= req_wrap_end;
            end
          end
        end
        BEAT_GEN_BURST: begin
          if (beat_valid_q && bus.beat_ready) begin
            if (beat_last_q) begin
              state_q      <= BEAT_GEN_IDLE;
              req_ready_q  <= 1'b1;
              beat_valid_q <= 1'b0;
              beat_last_q  <= 1'b0;
            end else begin
              beat_address_q <= ADDRESS_WIDTH'(next_address);
              beat_index_q   <= beat_index_q + 8'd1;
              beat_last_q    <= 8'(beat_index_q + 8'd1) == length_q;
            end
          end
        end
        default: begin
          state_q      <= BEAT_GEN_IDLE;
          req_ready_q  <= 1'b1;
          beat_valid_q <= 1'b0;
          beat_last_q  <= 1'b0;
        end
      endcase
    end
  end

  tvip_axi_strobe_calc #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_strobe_calc (
    .address_lsb (beat_address_q[7:0]),
    .size        (size_q),
    .strobe      (lane_strobe)
  );

  assign bus.req_ready    = req_ready_q;
  assign bus.req_error    = req_error_q;
  assign bus.beat_valid   = beat_valid_q;
  assign bus.beat_last    = beat_last_q;
  assign bus.beat_id      = id_q;
  assign bus.beat_address = beat_address_q;
  assign bus.beat_index   = beat_index_q;
  assign bus.beat_strobe  = beat_valid_q ? lane_strobe : '0;
  assign state            = state_q;

endmodule
